// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt requester for the core's interrupt/ack/RTI handshake.
// Optional ack timeout with sticky error flag is compiled in with `define IRQ_ACK_TIMEOUT_EN.
module interrupt_controller #(
  parameter int NUM_SRC     = 4,
  parameter int VEC_W       = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  input  logic               ack_i,
  input  logic               rti_done_i,
  output logic               interrupt_o,
  output logic [VEC_W-1:0]   vector_o,
  output logic               in_service_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] irq_mask_o,
  output logic               timeout_err_o
);

  if (((1 << VEC_W) < NUM_SRC) || (ACK_TIMEOUT < 1)) begin : g_param_chk
    $error("interrupt_controller: VEC_W too narrow for NUM_SRC or ACK_TIMEOUT < 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic               interrupt_q, interrupt_d;
  logic               in_service_q, in_service_d;

  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] eligible;
  logic [VEC_W-1:0]   win;
  logic               expire;

  assign edge_det = irq_src_i & ~src_q;
  assign eligible = pending_q & mask_q;

  // Descending scan so the lowest eligible index is the last (winning) assignment.
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win = VEC_W'(i);
    end
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign expire = (state_q == REQ) && !ack_i && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q | expire;
    if (state_q == REQ && !ack_i && !expire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err_o = timeout_q;
`else
  assign expire        = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    interrupt_d  = interrupt_q;
    in_service_d = in_service_q;
    pending_d    = pending_q;
    mask_d       = mask_we_i ? mask_wdata_i : mask_q;

    unique case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          vector_d    = win;
          interrupt_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (ack_i) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (VEC_W'(i) == vector_q) pending_d[i] = 1'b0;
          end
          interrupt_d  = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end else if (expire) begin
          interrupt_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SERVICE: begin
        if (rti_done_i) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // New edges are applied after the ack clear so a coincident re-request survives.
    pending_d = pending_d | edge_det;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      src_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      vector_q     <= '0;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= irq_src_i;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      vector_q     <= vector_d;
      interrupt_q  <= interrupt_d;
      in_service_q <= in_service_d;
    end
  end

  assign interrupt_o  = interrupt_q;
  assign vector_o     = vector_q;
  assign in_service_o = in_service_q;
  assign pending_o    = pending_q;
  assign irq_mask_o   = mask_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Requester side of the core's interrupt/ack handshake.
- Collects edge-triggered requests from NUM_SRC peripheral lines and applies a mask.
- Picks the highest-priority pending source, drives `interrupt` until the core returns `ack`, then holds the vector until the core reports RTI retirement.
- Sits outside the processor; feeds its `interrupt` input and consumes its `ack` output.

Parameters:
- NUM_SRC, 4: number of interrupt source lines.
- VEC_W, 2: width of the vector output; must satisfy 2^VEC_W >= NUM_SRC.
- ACK_TIMEOUT, 16: cycles to wait for `ack` before backing off (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_src  input  NUM_SRC  peripheral request lines; a rising edge raises a request.
- mask_we  input  1  mask write strobe.
- mask_wdata  input  NUM_SRC  new mask value; 1 = source enabled.
- ack  input  1  acknowledge from the core (ID stage).
- rti_done  input  1  one-cycle pulse when the core retires RTI.
- interrupt  output  1  request to the core.
- vector  output  VEC_W  index of the granted source.
- in_service  output  1  high from ack until rti_done.
- pending  output  NUM_SRC  latched pending requests.
- irq_mask  output  NUM_SRC  current mask.
- timeout_err  output  1  sticky ack-timeout flag.

Behaviour:
- **Reset values:**
  - interrupt=0, vector=0, in_service=0, pending=0, timeout_err=0.
  - irq_mask=all ones; internal src_q=0; state=IDLE.
  - Reset mid-handshake aborts immediately; no request survives.
- **Edge detect:**
  - edge[i] = irq_src[i] & ~src_q[i]; src_q <= irq_src every edge.
  - pending[i] sets on the edge where edge[i]=1, regardless of the mask or the current state.
  - Level-held lines raise only one request.
- **Mask:**
  - On mask_we, irq_mask <= mask_wdata at the next edge.
  - Masked pending bits are retained and become eligible once unmasked.
- **Priority:** eligible = pending & irq_mask; the lowest index wins.
- **FSM states:** IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, latch vector <= winning index and go to REQ.
    - interrupt is registered, so it is high from the next cycle onward.
    - Source edge to interrupt high is 2 cycles.
  - REQ: interrupt=1; vector is frozen, even if a higher-priority source arrives later.
    - On ack=1: clear pending[vector], set in_service=1, interrupt=0, go to SERVICE, all at the next edge.
    - rti_done is ignored in REQ.
  - SERVICE: interrupt=0; vector is held.
    - On rti_done: in_service=0, go to IDLE.
    - New edges still set pending during SERVICE; no nesting.
    - ack is ignored in SERVICE and in IDLE.
- **Simultaneous events:**
  - Set beats clear: if edge[vector] arrives in the same cycle as the ack that clears it, pending[vector] stays 1.
  - mask_we in the same cycle as the IDLE decision: the decision uses the old mask.
  - Masking the granted source while in REQ does not withdraw the request.
- **Back-to-back service:** rti_done in SERVICE with eligible != 0 passes through IDLE for one cycle, so interrupt re-asserts 2 cycles after rti_done.

Optional Feature:
- Macro: IRQ_ACK_TIMEOUT_EN.
- **Defined:**
  - A counter runs while in REQ.
  - If ACK_TIMEOUT cycles pass with no ack: set timeout_err (sticky until rst), drop interrupt, return to IDLE with pending unchanged.
  - Arbitration retries from IDLE on the following cycle.
  - ack in the same cycle the counter expires is honoured as a normal ack.
- **Undefined:** REQ waits for ack indefinitely; timeout_err is tied to 0 and no counter logic exists.

Test Plan:
- Single request: reset, pulse irq_src=4'b0100 → interrupt=1 two cycles later with vector=2; ack one cycle later → interrupt=0, in_service=1, pending=0; rti_done → in_service=0.
- Priority: raise irq_src=4'b1010 together → vector=1 serviced first; after rti_done, vector=3 is requested 2 cycles later.
- Mask: write mask=4'b1110, pulse src0 → no interrupt and pending=4'b0001; write mask=4'b1111 → interrupt with vector=0.
- Set-beats-clear: re-pulse src2 in the ack cycle for vector=2 → pending[2]=1 after ack; second request follows rti_done.
- Reset in REQ: assert rst while interrupt=1 → all outputs at reset values immediately, irq_mask=4'b1111.
- IRQ_ACK_TIMEOUT_EN, ACK_TIMEOUT=16: withhold ack → interrupt drops after 16 cycles, timeout_err=1, re-asserts 2 cycles later with the same vector.
